// File: rtl/gba_backup_sequencer_if.sv
// Backup transfer buses: HPS SD sector port plus the SDRAM backup-region channel.
interface gba_backup_sequencer_if;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [7:0]  sd_buff_addr;
    logic [15:0] sd_buff_dout;
    logic        sd_buff_wr;
    logic [15:0] sd_buff_din;
    logic [23:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;
    logic        mem_rnw;
    logic        mem_req;
    logic        mem_ack;

    // Handshakes: sd_rd/sd_wr are held until sd_ack rises, and sd_ack stays high for the whole
    // sector transfer; mem_req is a one-cycle pulse with at most one transaction outstanding,
    // completed by a one-cycle mem_ack (mem_din valid with it for reads).
    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din, mem_addr, mem_dout, mem_rnw, mem_req,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_din, mem_ack
    );
    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din, mem_addr, mem_dout, mem_rnw, mem_req,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_din, mem_ack
    );
endinterface

// File: rtl/gba_backup_sequencer.sv
// Moves GBA save data between the HPS SD sector port and SDRAM, one 512-byte sector at a time,
// through a local 128x32 buffer; also tracks unsaved writes and holds the core during loads.
module gba_backup_sequencer #(
    parameter int unsigned BASE_ADDR   = 8388608 + 65536,
    parameter int unsigned MAX_SECTORS = 256
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    gba_backup_sequencer_if.master bus,
    input  logic [8:0]             sector_count,
    input  logic                   bk_load,
    input  logic                   bk_save,
    input  logic                   autosave,
    input  logic                   osd_status,
    input  logic                   save_write,
    output logic                   busy,
    output logic                   loading,
    output logic                   pending,
    output logic [2:0]             dbg_state
);
    typedef enum logic [2:0] {IDLE, L_SD, L_FLUSH, S_FILL, S_SD} state_t;

    localparam logic [23:0] BASE24  = 24'(BASE_ADDR);
    localparam logic [8:0]  MAX_CNT = 9'(MAX_SECTORS);

    state_t      state;
    logic        load_q, save_q, osd_q, ack_q;
    logic [8:0]  count_q;
    logic [6:0]  idx;
    logic        mem_busy;
    logic [31:0] sector_buf [128];

    logic        load_edge, save_edge, auto_edge, ack_rise, ack_fall;
    logic        start_ok, more, ack_ok, last, pend_set;
    logic [31:0] lba_next;
    logic [6:0]  idx_next;
    logic [8:0]  count_in;
    logic [31:0] din_word;

    assign load_edge = bk_load & ~load_q;
    assign save_edge = bk_save & ~save_q;
    assign auto_edge = autosave & pending & osd_status & ~osd_q;
    assign ack_rise  = bus.sd_ack & ~ack_q;
    assign ack_fall  = ~bus.sd_ack & ack_q;
    assign start_ok  = (sector_count != 9'd0);
    assign count_in  = (sector_count > MAX_CNT) ? MAX_CNT : sector_count;
    assign lba_next  = bus.sd_lba + 32'd1;
    assign more      = (lba_next < {23'd0, count_q});
    assign ack_ok    = bus.mem_ack & mem_busy;
    assign idx_next  = idx + 7'd1;
    assign last      = (idx == 7'd127);
    assign pend_set  = save_write & ~osd_status;
    assign din_word  = sector_buf[bus.sd_buff_addr[7:1]];
    assign dbg_state = state;

    // Sector offset is taken modulo 2^24 along with the rest of the dword address.
    function automatic logic [23:0] dword_addr(input logic [16:0] lba_lo, input logic [6:0] i);
        return BASE24 + {lba_lo, 7'd0} + {17'd0, i};
    endfunction

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            load_q          <= 1'b0;
            save_q          <= 1'b0;
            osd_q           <= 1'b0;
            ack_q           <= 1'b0;
            count_q         <= 9'd0;
            idx             <= 7'd0;
            mem_busy        <= 1'b0;
            bus.sd_lba      <= 32'd0;
            bus.sd_rd       <= 1'b0;
            bus.sd_wr       <= 1'b0;
            bus.sd_buff_din <= 16'd0;
            bus.mem_req     <= 1'b0;
            bus.mem_rnw     <= 1'b1;
            bus.mem_addr    <= 24'd0;
            bus.mem_dout    <= 32'd0;
            busy            <= 1'b0;
            loading         <= 1'b0;
            pending         <= 1'b0;
        end else begin
            load_q      <= bk_load;
            save_q      <= bk_save;
            osd_q       <= osd_status;
            ack_q       <= bus.sd_ack;
            bus.mem_req <= 1'b0;
            if (pend_set) pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (start_ok && load_edge) begin
                        count_q    <= count_in;
                        bus.sd_lba <= 32'd0;
                        bus.sd_rd  <= 1'b1;
                        busy       <= 1'b1;
                        loading    <= 1'b1;
                        state      <= L_SD;
                    end else if (start_ok && (save_edge || auto_edge)) begin
                        count_q      <= count_in;
                        bus.sd_lba   <= 32'd0;
                        idx          <= 7'd0;
                        busy         <= 1'b1;
                        bus.mem_req  <= 1'b1;
                        bus.mem_rnw  <= 1'b1;
                        bus.mem_addr <= dword_addr(17'd0, 7'd0);
                        mem_busy     <= 1'b1;
                        state        <= S_FILL;
                    end
                end
                L_SD: begin
                    if (ack_rise) bus.sd_rd <= 1'b0;
                    if (ack_fall) begin
                        idx          <= 7'd0;
                        bus.mem_req  <= 1'b1;
                        bus.mem_rnw  <= 1'b0;
                        bus.mem_addr <= dword_addr(bus.sd_lba[16:0], 7'd0);
                        bus.mem_dout <= sector_buf[0];
                        mem_busy     <= 1'b1;
                        state        <= L_FLUSH;
                    end
                end
                L_FLUSH: begin
                    if (ack_ok) begin
                        mem_busy <= 1'b0;
                        if (!last) begin
                            idx          <= idx_next;
                            bus.mem_req  <= 1'b1;
                            bus.mem_addr <= dword_addr(bus.sd_lba[16:0], idx_next);
                            bus.mem_dout <= sector_buf[idx_next];
                            mem_busy     <= 1'b1;
                        end else if (more) begin
                            bus.sd_lba <= lba_next;
                            bus.sd_rd  <= 1'b1;
                            state      <= L_SD;
                        end else begin
                            busy    <= 1'b0;
                            loading <= 1'b0;
                            if (!pend_set) pending <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                S_FILL: begin
                    if (ack_ok) begin
                        mem_busy <= 1'b0;
                        if (!last) begin
                            idx          <= idx_next;
                            bus.mem_req  <= 1'b1;
                            bus.mem_addr <= dword_addr(bus.sd_lba[16:0], idx_next);
                            mem_busy     <= 1'b1;
                        end else begin
                            bus.sd_wr <= 1'b1;
                            state     <= S_SD;
                        end
                    end
                end
                S_SD: begin
                    bus.sd_buff_din <= bus.sd_buff_addr[0] ? din_word[31:16] : din_word[15:0];
                    if (ack_rise) bus.sd_wr <= 1'b0;
                    if (ack_fall) begin
                        if (more) begin
                            bus.sd_lba   <= lba_next;
                            idx          <= 7'd0;
                            bus.mem_req  <= 1'b1;
                            bus.mem_rnw  <= 1'b1;
                            bus.mem_addr <= dword_addr(lba_next[16:0], 7'd0);
                            mem_busy     <= 1'b1;
                            state        <= S_FILL;
                        end else begin
                            busy  <= 1'b0;
                            if (!pend_set) pending <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Buffer has no reset: its contents are meaningless outside a transfer.
    always_ff @(posedge clk_sys) begin
        if (state == L_SD && bus.sd_buff_wr) begin
            if (bus.sd_buff_addr[0]) sector_buf[bus.sd_buff_addr[7:1]][31:16] <= bus.sd_buff_dout;
            else                     sector_buf[bus.sd_buff_addr[7:1]][15:0]  <= bus.sd_buff_dout;
        end else if (state == S_FILL && ack_ok) begin
            sector_buf[idx] <= bus.mem_din;
        end
    end
endmodule

// File: tb/tb_gba_backup_sequencer.sv
// Randomized bench for gba_backup_sequencer: HPS and SDRAM models, scoreboard of expected
// memory transactions and SD save words derived from the sector/dword mapping.
module tb_gba_backup_sequencer;
    localparam logic [23:0] BASE = 24'h810000;

    logic clk_sys = 1'b0;
    logic reset_n;
    always #5 clk_sys = ~clk_sys;

    gba_backup_sequencer_if bus ();
    logic [8:0] sector_count;
    logic       bk_load, bk_save, autosave, osd_status, save_write;
    logic       busy, loading, pending;
    logic [2:0] dbg_state;

    gba_backup_sequencer dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .bus         (bus),
        .sector_count(sector_count),
        .bk_load     (bk_load),
        .bk_save     (bk_save),
        .autosave    (autosave),
        .osd_status  (osd_status),
        .save_write  (save_write),
        .busy        (busy),
        .loading     (loading),
        .pending     (pending),
        .dbg_state   (dbg_state)
    );

    int          checks = 0;
    int          failures = 0;
    logic [56:0] exp_q[$];        // {rnw, addr, write data}
    logic [15:0] sd_exp_q[$];
    logic [31:0] mem_model [int];
    logic [15:0] hps_data [4][256];
    int          hps_next_lba = 0;
    int          hps_total = 0;
    int          mem_wr_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got unexpected event expected none", name);
    endtask

    function automatic logic [31:0] mem_rd(input logic [23:0] a);
        if (mem_model.exists(int'(a))) return mem_model[int'(a)];
        return 32'h0;
    endfunction

    function automatic logic [23:0] region_addr(input int s, input int d);
        return BASE + 24'(s * 128 + d);
    endfunction

    // SDRAM model and mem-side monitor: pops the scoreboard on every mem_req.
    initial begin : mem_responder
        bit          pend;
        int          lat;
        logic [23:0] p_addr;
        logic        p_rnw;
        logic [31:0] p_data;
        logic [56:0] e;
        pend = 0;
        lat = 0;
        bus.mem_ack = 1'b0;
        bus.mem_din = 32'h0;
        forever begin
            @(negedge clk_sys);
            bus.mem_ack = 1'b0;
            if (reset_n !== 1'b1) begin
                pend = 0;
            end else begin
                if (pend) begin
                    lat--;
                    if (lat == 0) begin
                        pend = 0;
                        bus.mem_ack = 1'b1;
                        if (p_rnw) bus.mem_din = mem_rd(p_addr);
                        else mem_model[int'(p_addr)] = p_data;
                    end
                end
                if (bus.mem_req === 1'b1) begin
                    check("mem_one_outstanding", 64'(pend), 0);
                    if (exp_q.size() == 0) begin
                        fail_now("mem_unexpected_req");
                    end else begin
                        e = exp_q.pop_front();
                        check("mem_rnw", 64'(bus.mem_rnw), 64'(e[56]));
                        check("mem_addr", 64'(bus.mem_addr), 64'(e[55:32]));
                        if (!e[56]) begin
                            check("mem_dout", 64'(bus.mem_dout), 64'(e[31:0]));
                            check("loading_in_flush", 64'(loading), 1);
                            mem_wr_seen++;
                        end
                    end
                    pend = 1;
                    lat = $urandom_range(1, 3);
                    p_addr = bus.mem_addr;
                    p_rnw = bus.mem_rnw;
                    p_data = bus.mem_dout;
                end
            end
        end
    end

    // HPS model: serves sector reads from hps_data, checks save words against sd_exp_q.
    initial begin : hps_model
        bit is_rd;
        int lba;
        bus.sd_ack = 1'b0;
        bus.sd_buff_addr = 8'h0;
        bus.sd_buff_dout = 16'h0;
        bus.sd_buff_wr = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (reset_n === 1'b1 && (bus.sd_rd === 1'b1 || bus.sd_wr === 1'b1)) begin
                is_rd = bus.sd_rd;
                lba = hps_next_lba;
                hps_next_lba++;
                check("sd_lba", 64'(bus.sd_lba), 64'(lba));
                if (!is_rd) check("reads_before_sd_wr", 64'(exp_q.size()), 64'(128 * (hps_total - lba - 1)));
                repeat ($urandom_range(1, 4)) @(negedge clk_sys);
                bus.sd_ack = 1'b1;
                @(negedge clk_sys);
                check("sd_req_drop", 64'({bus.sd_rd, bus.sd_wr}), 0);
                for (int j = 0; j < 256; j++) begin
                    bus.sd_buff_addr = 8'(j);
                    if (is_rd) begin
                        bus.sd_buff_dout = hps_data[lba & 3][j];
                        bus.sd_buff_wr = 1'b1;
                        @(negedge clk_sys);
                        bus.sd_buff_wr = 1'b0;
                        if ($urandom_range(0, 3) == 0) @(negedge clk_sys);
                    end else begin
                        @(negedge clk_sys);
                        if (sd_exp_q.size() == 0) fail_now("sd_unexpected_word");
                        else check("sd_buff_din", 64'(bus.sd_buff_din), 64'(sd_exp_q.pop_front()));
                    end
                end
                bus.sd_ack = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        check(name, 64'(busy), 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_sd_lba"}, 64'(bus.sd_lba), 0);
        check({tag, "_sd_rd"}, 64'(bus.sd_rd), 0);
        check({tag, "_sd_wr"}, 64'(bus.sd_wr), 0);
        check({tag, "_sd_buff_din"}, 64'(bus.sd_buff_din), 0);
        check({tag, "_mem_req"}, 64'(bus.mem_req), 0);
        check({tag, "_mem_rnw"}, 64'(bus.mem_rnw), 1);
        check({tag, "_mem_addr"}, 64'(bus.mem_addr), 0);
        check({tag, "_mem_dout"}, 64'(bus.mem_dout), 0);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_loading"}, 64'(loading), 0);
        check({tag, "_pending"}, 64'(pending), 0);
        check({tag, "_state"}, 64'(dbg_state), 0);
    endtask

    task automatic random_sectors(input int count);
        for (int s = 0; s < count; s++)
            for (int i = 0; i < 256; i++) hps_data[s][i] = 16'($urandom);
    endtask

    task automatic start_load(input int count, input bit with_save);
        sector_count = 9'(count);
        hps_next_lba = 0;
        hps_total = count;
        mem_wr_seen = 0;
        for (int s = 0; s < count; s++)
            for (int d = 0; d < 128; d++)
                exp_q.push_back({1'b0, region_addr(s, d), hps_data[s][2 * d + 1], hps_data[s][2 * d]});
        bk_load = 1'b1;
        bk_save = with_save;
        @(negedge clk_sys);
        check("load_busy_next", 64'(busy), 1);
        check("load_sd_rd_next", 64'(bus.sd_rd), 1);
        check("load_loading_next", 64'(loading), 1);
        bk_load = 1'b0;
        bk_save = 1'b0;
    endtask

    task automatic start_save(input int count, input bit via_osd);
        logic [31:0] w;
        sector_count = 9'(count);
        hps_next_lba = 0;
        hps_total = count;
        for (int s = 0; s < count; s++) begin
            for (int d = 0; d < 128; d++) exp_q.push_back({1'b1, region_addr(s, d), 32'h0});
            for (int j = 0; j < 256; j++) begin
                w = mem_rd(region_addr(s, j / 2));
                sd_exp_q.push_back((j % 2 == 1) ? w[31:16] : w[15:0]);
            end
        end
        if (via_osd) osd_status = 1'b1;
        else bk_save = 1'b1;
        @(negedge clk_sys);
        check("save_busy_next", 64'(busy), 1);
        check("save_mem_req_next", 64'(bus.mem_req), 1);
        check("save_not_loading", 64'(loading), 0);
        bk_save = 1'b0;
    endtask

    task automatic pulse_save_write();
        save_write = 1'b1;
        @(negedge clk_sys);
        save_write = 1'b0;
        @(negedge clk_sys);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        reset_n = 1'b0;
        sector_count = 9'd0;
        bk_load = 1'b0;
        bk_save = 1'b0;
        autosave = 1'b0;
        osd_status = 1'b0;
        save_write = 1'b0;
        tick(3);
        check_reset("por");
        reset_n = 1'b1;
        tick(2);

        // Two-sector load with the counting word pattern.
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 256; i++) hps_data[s][i] = 16'(s * 256 + i);
        start_load(2, 1'b0);
        wait_idle("load2_idle", 6000);
        check("load2_dword0", 64'(mem_rd(BASE)), 64'h00010000);
        check("load2_dword128", 64'(mem_rd(BASE + 24'd128)), 64'h01010100);
        check("load2_drained", 64'(exp_q.size()), 0);
        check("load2_loading_low", 64'(loading), 0);

        // One-sector save of dword k = k*0x01010101.
        for (int k = 0; k < 128; k++) mem_model[int'(region_addr(0, k))] = 32'(k) * 32'h01010101;
        pulse_save_write();
        check("save_pending_set", 64'(pending), 1);
        start_save(1, 1'b0);
        wait_idle("save1_idle", 6000);
        check("save1_pending_clear", 64'(pending), 0);
        check("save1_drained", 64'(exp_q.size() + sd_exp_q.size()), 0);

        // Autosave on OSD open, then the same with autosave off.
        pulse_save_write();
        check("auto_pending_set", 64'(pending), 1);
        autosave = 1'b1;
        start_save(1, 1'b1);
        wait_idle("auto_idle", 6000);
        check("auto_pending_clear", 64'(pending), 0);
        osd_status = 1'b0;
        autosave = 1'b0;
        tick(2);
        pulse_save_write();
        osd_status = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_sys);
            check("noauto_busy", 64'(busy), 0);
        end
        check("noauto_pending_kept", 64'(pending), 1);
        osd_status = 1'b0;
        tick(2);

        // Load and save edges together: load wins; a later save edge is dropped.
        random_sectors(1);
        start_load(1, 1'b1);
        n = 0;
        while (mem_wr_seen < 10 && n < 3000) begin
            @(negedge clk_sys);
            n++;
        end
        check("both_reached_flush", 64'(mem_wr_seen >= 10), 1);
        bk_save = 1'b1;
        tick(1);
        bk_save = 1'b0;
        wait_idle("both_idle", 4000);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_sys);
            check("both_no_save", 64'({busy, bus.mem_req}), 0);
        end
        check("both_drained", 64'(exp_q.size()), 0);

        // sector_count == 0 disables the block.
        sector_count = 9'd0;
        bk_load = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_sys);
            bk_load = 1'b0;
            check("zero_idle", 64'({busy, bus.sd_rd}), 0);
        end

        // Reset in the middle of a flush, then a clean two-sector load.
        random_sectors(1);
        start_load(1, 1'b0);
        n = 0;
        while (mem_wr_seen < 51 && n < 3000) begin
            @(negedge clk_sys);
            n++;
        end
        check("abort_reached_index50", 64'(mem_wr_seen >= 51), 1);
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        @(negedge clk_sys);
        check_reset("abort");
        tick(2);
        reset_n = 1'b1;
        tick(2);
        random_sectors(2);
        start_load(2, 1'b0);
        wait_idle("reload_idle", 6000);
        check("reload_drained", 64'(exp_q.size()), 0);
        check("reload_dword133", 64'(mem_rd(BASE + 24'd133)), 64'({hps_data[1][11], hps_data[1][10]}));

        // Random mix of loads and saves.
        for (int r = 0; r < 5; r++) begin
            n = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) begin
                random_sectors(n);
                start_load(n, 1'b0);
            end else begin
                for (int k = 0; k < n * 128; k++) mem_model[int'(region_addr(0, k))] = $urandom;
                start_save(n, 1'b0);
            end
            wait_idle("rand_idle", 12000);
            check("rand_drained", 64'(exp_q.size() + sd_exp_q.size()), 0);
            tick($urandom_range(1, 5));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gba_backup_sequencer.md
# gba_backup_sequencer

Sequences backup-memory (SRAM/Flash/EEPROM save data) transfers between the HPS SD sector interface and the GBA external-memory bus channel. It handles load (SD -> memory) and save (memory -> SD), one 512-byte sector at a time, through a local 128x32 sector buffer. It tracks unsaved writes for autosave and holds the core in reset while a load is in progress. It sits in `emu` between `hps_io` (sd_* ports) and the SDRAM channel that serves the GBA backup region.

## Interface
- BASE_ADDR, 8388608+65536, dword address of sector 0 of the backup region
- MAX_SECTORS, 256, upper bound on `sector_count`
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- sector_count  in  9  sectors to transfer; 0 disables the block (sampled at start)
- bk_load  in  1  level; a rising edge starts a load
- bk_save  in  1  level; a rising edge starts a save
- autosave  in  1  enables a save when the OSD opens
- osd_status  in  1  OSD open
- save_write  in  1  one-cycle strobe; the core wrote backup memory
- sd_lba  out  32  sector number
- sd_rd / sd_wr  out  1  sector read/write request
- sd_ack  in  1  HPS transfer in progress
- sd_buff_addr  in  8  16-bit word index within the sector
- sd_buff_dout  in  16  load data
- sd_buff_wr  in  1  load data strobe
- sd_buff_din  out  16  save data, registered
- mem_addr  out  24  dword address [25:2]
- mem_dout  out  32  write data
- mem_din  in  32  read data
- mem_rnw  out  1  1 = read
- mem_req  out  1  one-cycle request pulse
- mem_ack  in  1  one-cycle completion pulse
- busy  out  1  state is not IDLE
- loading  out  1  load in progress; OR'd into the core reset
- pending  out  1  unsaved writes exist

## Operation
- States: IDLE, L_SD, L_FLUSH, S_FILL, S_SD.
- IDLE:
  - load edge -> L_SD, with sd_lba=0, sd_rd=1.
  - save edge, or (autosave & pending & rising edge of osd_status) -> S_FILL, with sd_lba=0.
  - Load and save in the same cycle: load wins.
  - Either request with sector_count==0 is ignored.
  - Edges arriving while busy are discarded, not queued.
- L_SD:
  - sd_rd drops on the sd_ack rise.
  - Each sd_buff_wr writes the buffer: dword `sd_buff_addr[7:1]`; even address -> bits [15:0], odd address -> [31:16].
  - On the sd_ack fall -> L_FLUSH, index=0.
- L_FLUSH:
  - Issue 128 writes, one outstanding at a time: mem_addr = BASE_ADDR + sd_lba*128 + index, mem_dout = buf[index], mem_rnw=0.
  - On mem_ack: index+1. After index 127's ack: if sd_lba+1 < count, then sd_lba+1 and sd_rd=1 -> L_SD; otherwise -> IDLE.
- S_FILL:
  - Issue 128 reads at the same addresses; mem_din is stored to buf[index] on mem_ack.
  - After the last ack: sd_wr=1 -> S_SD.
- S_SD:
  - sd_wr drops on the sd_ack rise.
  - sd_buff_din = the half of buf[sd_buff_addr[7:1]] selected by sd_buff_addr[0], registered every cycle.
  - On the sd_ack fall: next sector -> S_FILL, or last sector -> IDLE.
- pending:
  - Set by save_write unless osd_status is high.
  - Cleared when a save completes; a save_write in that same cycle wins (pending stays 1).
  - Cleared on load completion.
- loading = 1 from leaving IDLE for L_SD until the return to IDLE.
- The address offset `sd_lba*128` is computed in 24 bits and wraps modulo 2^24.

## Timing
- Reset values: sd_lba=0, sd_rd=sd_wr=0, sd_buff_din=0, mem_req=0, mem_rnw=1, mem_addr=0, mem_dout=0, busy=loading=pending=0, state IDLE.
- The edge detectors are reset to 0, so a level already high at reset release counts as an edge.
- A request edge at cycle N gives busy=1 and sd_rd (or mem_req) at N+1.
- mem_req:
  - Next mem_req is at the earliest one cycle after the previous mem_ack.
  - mem_req never pulses while the previous transaction is outstanding.
  - mem_ack is ignored outside L_FLUSH and S_FILL.
- sd_buff_din is valid one cycle after sd_buff_addr changes.
- A flush takes 128 acks; with 2-cycle ack latency it is ≥384 cycles.
- Asserting reset_n low mid-operation aborts immediately: outputs take their reset values and buffer contents are don't-care.
- sd_ack pulses seen in IDLE are ignored.

## Test plan
- Load, sector_count=2:
  - Stimulus: HPS model returns sectors of word pattern i (sector 0) and 0x100+i (sector 1).
  - Required: 256 mem writes; dword BASE+0 = 0x00010000, BASE+128 = 0x01010100; sd_lba goes 0 then 1; loading is high throughout and falls at the final ack.
- Save, sector_count=1:
  - Stimulus: memory preloaded with dword k = k*0x01010101.
  - Required: 128 reads before sd_wr rises; sd_buff_din at addr 3 = 0x0101 (high half of dword 1); pending clears.
- Autosave:
  - Stimulus: save_write pulse, then osd_status rises with autosave=1.
  - Required: save starts the next cycle. With autosave=0 no save starts and pending stays 1.
- Simultaneous bk_load and bk_save edges: load runs. A second save edge during the load is dropped; busy returns to 0 without a save.
- sector_count=0 with a load edge: busy stays 0, no sd_rd.
- reset_n asserted mid-L_FLUSH (index 50): all outputs take reset values. A fresh load after release completes correctly.
